// File: rtl/pe_pkg.sv
// Shared defaults and FSM state type for the PE-row result drain.
package pe_pkg;

  localparam int unsigned NPeDefault  = 4;
  localparam int unsigned OutWDefault = 12;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDrain   = 2'd2
  } drain_state_t;

endpackage

// File: rtl/pe_lin_drain.sv
// Collects skewed PE results after a tile's last activation and streams them out lane by lane.
// Optional m_idx lane-index output is enabled by defining PE_DRAIN_IDX_EN.
module pe_lin_drain
  import pe_pkg::*;
#(
  parameter int unsigned N_PE   = NPeDefault,
  parameter int unsigned OUT_W  = OutWDefault,
  parameter int unsigned PE_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fire,
  input  logic             last,
  input  logic [OUT_W-1:0] outs [0:N_PE-1],
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             ovf
`ifdef PE_DRAIN_IDX_EN
  ,
  output logic [((N_PE > 1) ? $clog2(N_PE) : 1)-1:0] m_idx
`endif
);

  localparam int unsigned LaneW   = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int unsigned CntW    = $clog2(PE_LAT + N_PE);
  // Counter value seen on the edge that captures the final lane.
  localparam int unsigned CapLast = PE_LAT + N_PE - 2;

  drain_state_t r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [LaneW-1:0] r_lane, w_lane_d, w_lane_nxt;
  logic             r_valid, w_valid_d;
  logic [OUT_W-1:0] r_data, w_data_d;
  logic             r_last, w_last_d;
  logic             r_busy, w_busy_d;
  logic             r_ovf, w_ovf_d;
  logic [OUT_W-1:0] r_buf [0:N_PE-1];

  logic w_trig, w_xfer, w_final;
  int   w_cap_idx;

  assign w_trig     = fire & last;
  assign w_xfer     = r_valid & m_ready;
  assign w_final    = w_xfer && (r_lane == LaneW'(N_PE - 1));
  assign w_lane_nxt = r_lane + LaneW'(1);
  // Edge E0+k has counter k-1 beforehand; lane k-PE_LAT is captured on it.
  assign w_cap_idx  = int'(r_cnt) + 1 - int'(PE_LAT);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_lane_d  = r_lane;
    w_valid_d = r_valid;
    w_data_d  = r_data;
    w_last_d  = r_last;
    w_ovf_d   = r_ovf;
    unique case (r_state)
      StIdle: begin
        if (w_trig) begin
          w_state_d = StCapture;
          w_cnt_d   = '0;
        end
      end
      StCapture: begin
        if (w_trig) w_ovf_d = 1'b1;
        w_cnt_d = r_cnt + CntW'(1);
        if (r_cnt == CntW'(CapLast)) begin
          w_state_d = StDrain;
          w_valid_d = 1'b1;
          w_data_d  = r_buf[0];
          w_last_d  = (N_PE == 1);
          w_lane_d  = '0;
        end
      end
      StDrain: begin
        if (w_final) begin
          w_valid_d = 1'b0;
          w_last_d  = 1'b0;
          w_lane_d  = '0;
          if (w_trig) begin
            w_state_d = StCapture;
            w_cnt_d   = '0;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          if (w_trig) w_ovf_d = 1'b1;
          if (w_xfer) begin
            w_lane_d = w_lane_nxt;
            w_data_d = r_buf[w_lane_nxt];
            w_last_d = (w_lane_nxt == LaneW'(N_PE - 1));
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_lane  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_lane  <= w_lane_d;
      r_valid <= w_valid_d;
      r_data  <= w_data_d;
      r_last  <= w_last_d;
      r_busy  <= w_busy_d;
      r_ovf   <= w_ovf_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N_PE); i++) begin
      if (rstn && r_state == StCapture && w_cap_idx == i) r_buf[i] <= outs[i];
    end
  end

  assign m_valid = r_valid;
  assign m_data  = r_data;
  assign m_last  = r_last;
  assign busy    = r_busy;
  assign ovf     = r_ovf;
`ifdef PE_DRAIN_IDX_EN
  assign m_idx   = r_lane;
`endif

endmodule

// File: tb/tb_pe_lin_drain.sv
// Directed self-checking bench for pe_lin_drain (N_PE=4, OUT_W=12, PE_LAT=1).
module tb_pe_lin_drain;

  logic        clk;
  logic        rstn;
  logic        fire;
  logic        last;
  logic [11:0] outs [0:3];
  logic        m_valid;
  logic        m_ready;
  logic [11:0] m_data;
  logic        m_last;
  logic        busy;
  logic        ovf;
`ifdef PE_DRAIN_IDX_EN
  logic [1:0]  m_idx;
`endif

  int checks;
  int failures;

  pe_lin_drain #(
    .N_PE   (4),
    .OUT_W  (12),
    .PE_LAT (1)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .fire    (fire),
    .last    (last),
    .outs    (outs),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy),
    .ovf     (ovf)
`ifdef PE_DRAIN_IDX_EN
    ,
    .m_idx   (m_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rstn;
    logic        fire;
    logic        last;
    logic        rdy;
    logic [47:0] o;      // {lane3, lane2, lane1, lane0}
    logic        ev;
    logic        chk_d;
    logic [11:0] ed;
    logic        el;
    logic        eb;
    logic        eo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_outs(input logic [47:0] v);
    for (int i = 0; i < 4; i++) outs[i] = v[i*12 +: 12];
  endtask

  // Drains one tile, checking every beat; optionally triggers a new tile on the final transfer.
  task automatic drain_check(input string nm, input logic [47:0] exp, input bit bp,
                             input bit trig_last, input logic [47:0] nxt);
    bit          pat [5];
    int          n;
    int          cyc;
    bit          stall;
    logic [11:0] hd;
    logic        hl;
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    n   = 0;
    cyc = 0;
    while (n < 4 && cyc < 64) begin
      m_ready = bp ? pat[cyc % 5] : 1'b1;
      stall   = m_valid && !m_ready;
      hd      = m_data;
      hl      = m_last;
      if (m_valid && m_ready) begin
        chk($sformatf("%s_data%0d", nm, n), 32'(m_data), 32'(exp[n*12 +: 12]));
        chk($sformatf("%s_last%0d", nm, n), 32'(m_last), 32'(n == 3));
`ifdef PE_DRAIN_IDX_EN
        chk($sformatf("%s_idx%0d", nm, n), 32'(m_idx), 32'(n));
`endif
        if (trig_last && n == 3) begin
          fire = 1'b1;
          last = 1'b1;
          set_outs(nxt);
        end
        n++;
      end
      step();
      fire = 1'b0;
      last = 1'b0;
      if (stall) begin
        chk($sformatf("%s_hold_valid", nm), 32'(m_valid), 32'd1);
        chk($sformatf("%s_hold_data", nm), 32'(m_data), 32'(hd));
        chk($sformatf("%s_hold_last", nm), 32'(m_last), 32'(hl));
      end
      cyc++;
    end
    if (n < 4) chk($sformatf("%s_timeout_beats", nm), 32'(n), 32'd4);
    chk($sformatf("%s_end_valid", nm), 32'(m_valid), 32'd0);
    m_ready = 1'b1;
  endtask

  localparam logic [47:0] TileBasic = {12'h004, 12'h003, 12'h002, 12'h001};
  localparam logic [47:0] TileSkew  = {12'h4D4, 12'h3C3, 12'h2B2, 12'h1A1};
  localparam logic [47:0] TileBp    = {12'hA44, 12'hA33, 12'hA22, 12'hA11};
  localparam logic [47:0] TileA     = {12'h0D4, 12'h0C3, 12'h0B2, 12'h0A1};
  localparam logic [47:0] TileB     = {12'h5E8, 12'h5E7, 12'h5E6, 12'h5E5};
  localparam logic [47:0] TileC     = {12'h704, 12'h703, 12'h702, 12'h701};
  localparam logic [47:0] TileD     = {12'h844, 12'h833, 12'h822, 12'h811};

  vec_t tbl [14];

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    fire     = 1'b0;
    last     = 1'b0;
    m_ready  = 1'b1;
    set_outs(48'h0);

    //             rstn  fire  last  rdy   outs       ev    chkd  ed       el    eb    eo
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, TileBasic, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, TileBasic, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, TileBasic, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, TileBasic, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, TileBasic, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, TileBasic, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, TileBasic, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, TileBasic, 1'b1, 1'b1, 12'h001, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, TileBasic, 1'b1, 1'b1, 12'h002, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, TileBasic, 1'b1, 1'b1, 12'h003, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, TileBasic, 1'b1, 1'b1, 12'h004, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, TileBasic, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, TileBasic, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, TileBasic, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};

    // Reset and basic tile, one row per clock edge.
    for (int r = 0; r < 14; r++) begin
      rstn    = tbl[r].rstn;
      fire    = tbl[r].fire;
      last    = tbl[r].last;
      m_ready = tbl[r].rdy;
      set_outs(tbl[r].o);
      step();
      chk($sformatf("tbl%0d_valid", r), 32'(m_valid), 32'(tbl[r].ev));
      if (tbl[r].chk_d) chk($sformatf("tbl%0d_data", r), 32'(m_data), 32'(tbl[r].ed));
      chk($sformatf("tbl%0d_last", r), 32'(m_last), 32'(tbl[r].el));
      chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].eb));
      chk($sformatf("tbl%0d_ovf", r), 32'(ovf), 32'(tbl[r].eo));
    end

    // Skew: each lane holds its real value only at edge E0+1+i.
    set_outs({4{12'hFFF}});
    fire = 1'b1;
    last = 1'b1;
    step();
    fire = 1'b0;
    last = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      for (int i = 0; i < 4; i++) outs[i] = (k == 1 + i) ? TileSkew[i*12 +: 12] : 12'hFFF;
      step();
    end
    set_outs({4{12'hFFF}});
    chk("skew_valid_rise", 32'(m_valid), 32'd1);
    drain_check("skew", TileSkew, 1'b0, 1'b0, 48'h0);

    // Backpressure with ready pattern 0,1,0,0,1,...
    set_outs(TileBp);
    fire = 1'b1;
    last = 1'b1;
    step();
    fire = 1'b0;
    last = 1'b0;
    drain_check("bp", TileBp, 1'b1, 1'b0, 48'h0);
    chk("bp_ovf", 32'(ovf), 32'd0);

    // Overlap: trigger at E0+2 dropped; trigger on final transfer accepted.
    set_outs(TileA);
    fire = 1'b1;
    last = 1'b1;
    step();
    fire = 1'b0;
    last = 1'b0;
    step();
    fire = 1'b1;
    last = 1'b1;
    step();
    fire = 1'b0;
    last = 1'b0;
    chk("ovl_ovf_set", 32'(ovf), 32'd1);
    chk("ovl_busy", 32'(busy), 32'd1);
    drain_check("ovlA", TileA, 1'b0, 1'b1, TileB);
    chk("ovl_rearm_busy", 32'(busy), 32'd1);
    chk("ovl_ovf_hold", 32'(ovf), 32'd1);
    drain_check("ovlB", TileB, 1'b0, 1'b0, 48'h0);
    chk("ovlB_busy_drop", 32'(busy), 32'd0);
    chk("ovlB_ovf_sticky", 32'(ovf), 32'd1);

    // Reset mid-drain after two beats, then a fresh tile.
    set_outs(TileC);
    m_ready = 1'b1;
    fire    = 1'b1;
    last    = 1'b1;
    step();
    fire = 1'b0;
    last = 1'b0;
    for (int c = 0; c < 20 && !m_valid; c++) step();
    chk("rst_first_valid", 32'(m_valid), 32'd1);
    step();
    step();
    chk("rst_pre_data", 32'(m_data), 32'(TileC[24 +: 12]));
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    step();
    chk("rst_idle", 32'(busy), 32'd0);
    set_outs(TileD);
    fire = 1'b1;
    last = 1'b1;
    step();
    fire = 1'b0;
    last = 1'b0;
    drain_check("fresh", TileD, 1'b0, 1'b0, 48'h0);
    chk("fresh_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
